sensor_pulse_capture: RTL and testbench
=======================================

# sensor_pulse_capture

Downstream consumer of the sensor-input pad cell. Takes the registered envelope bit from the sensor's input pad, synchronises and optionally deglitches it, and measures each high pulse as a start timestamp plus a width in clock cycles. Completed pulse records go through a 4-entry FIFO to the pulse decoder over a valid/ready handshake.

## Interface
- `TS_WIDTH`, 24: width of the shared timestamp bus and of the recorded start time.
- `W_WIDTH`, 16: width of the pulse-width field. The width saturates at all-ones.
- `MIN_WIDTH`, 4: pulses with a width below this value are discarded.
- `FILTER_LEN`, 3: deglitch length in cycles. Used only when `SENSOR_PULSE_FILTER_EN` is defined.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `envelope_in` in 1: sensor envelope from the pad cell's `D_IN_0`. Asynchronous to `clk`.
- `timestamp` in TS_WIDTH: free-running system timestamp.
- `pulse_valid` out 1: the head FIFO record is presented.
- `pulse_ready` in 1: the consumer accepts the record.
- `pulse_start` out TS_WIDTH: timestamp at the detected rising edge.
- `pulse_width` out W_WIDTH: high duration in `clk` cycles.
- `overflow` out 1: sticky flag, set when a record is dropped because the FIFO is full.
- `overflow_clear` in 1: clears `overflow`.

## Operation
- **Synchroniser:** two flops `s1`→`s2`, then an edge-history flop `s3` after the optional filter.
- **Rise detect:** `s3`-input high and `s3` low. **Fall detect:** `s3`-input low and `s3` high.
- **FSM states:**
  - IDLE: on rise, latch `timestamp` into `start_q`, set `width_q` = 1, go to HIGH.
  - HIGH: each cycle `width_q` increments, saturating at 2^W_WIDTH−1. On fall, go to IDLE and evaluate the record.
- **Record evaluation:**
  - `width_q` < MIN_WIDTH: discard silently.
  - Otherwise push `{start_q, width_q}` into the FIFO.
  - FIFO full: drop the new record (existing entries are untouched) and set `overflow`.
- **Width rule:** `width_q` equals the number of cycles the filtered signal was high.
- **FIFO:** 4 entries, first-word fall-through. The head is driven on `pulse_start` / `pulse_width` when `pulse_valid` = 1.
- **Pop:** occurs on `pulse_valid && pulse_ready`. Push and pop in the same cycle are both honoured. When full, a same-cycle pop frees a slot, so the push succeeds.
- **`timestamp` wrap-around:** ignored. The consumer handles modular arithmetic.
- **`overflow` priority:** set has priority over `overflow_clear` in the same cycle. Otherwise `overflow_clear` clears the flag.

## Timing
- **Reset values:** `pulse_valid` = 0, `pulse_start` = 0, `pulse_width` = 0, `overflow` = 0. FSM in IDLE, FIFO empty, sync and filter flops = 0.
- **Reset mid-pulse:** the record is lost. If `envelope_in` is still high after reset, a new rise is detected once the synchroniser fills. `start_q` then reflects the post-reset time.
- **Latency, filter out:**
  - `envelope_in` first sampled high at edge k → rise detected in cycle k+2, with `start_q` = `timestamp` of cycle k+2.
  - Last-high sample at k+N−1, first low at k+N → fall in cycle k+N+2 → `pulse_valid` high at k+N+3 if the FIFO was empty.
- **Latency, filter in:** both edges are delayed by FILTER_LEN extra cycles. Width is unchanged for pulses longer than FILTER_LEN.
- **Handshake:**
  - `pulse_valid` stays high and the data stays stable until accepted.
  - After a pop, the next entry is presented in the following cycle with no bubble.
- **Simultaneous fall and rise:** impossible, since one edge is evaluated per cycle. A low gap of 1 cycle yields two separate records.

## Configuration
- `SENSOR_PULSE_FILTER_EN` defined:
  - A counter-based deglitcher sits between `s2` and `s3`.
  - The filtered level changes only after `s2` has held the new value for FILTER_LEN consecutive cycles.
  - Shorter high or low excursions are suppressed entirely.
- Not defined: `s2` feeds `s3` directly, with no suppression and no extra latency. The `FILTER_LEN` parameter is ignored.

## Test plan
- **Basic pulse (filter out):** `timestamp` counts from 0; `envelope_in` high for 10 cycles starting at edge 5, `pulse_ready` = 1 → one record: `pulse_start` = 7, `pulse_width` = 10, `pulse_valid` high at edge 18.
- **Runt rejection:** 3-cycle pulse with MIN_WIDTH = 4 → no `pulse_valid`. A following 4-cycle pulse → record with `pulse_width` = 4.
- **Backpressure and overflow:** `pulse_ready` = 0, six 8-cycle pulses → first four records held in order, `overflow` = 1. Then `pulse_ready` = 1 → exactly 4 pops, widths 8, start times of pulses 1–4. `overflow_clear` → `overflow` = 0.
- **Saturation:** W_WIDTH = 4, 20-cycle pulse → `pulse_width` = 15.
- **Reset mid-pulse:** `reset` asserted at cycle 6 of a 12-cycle pulse → outputs at reset values the next cycle. `envelope_in` still high → one record with start after reset and width equal to the remaining high cycles minus synchroniser refill.
- **Filter (`SENSOR_PULSE_FILTER_EN`, FILTER_LEN = 3):**
  - 2-cycle pulse → no record.
  - 10-cycle pulse containing a 2-cycle low glitch → one record, width 10, start delayed 3 cycles versus the filter-out build.

Source files
------------

// File: rtl/sensor_pulse_capture.sv
// sensor_pulse_capture: sync, optionally deglitch (SENSOR_PULSE_FILTER_EN) and time sensor pulses into a 4-entry FWFT FIFO
// Records are {start timestamp, saturating width}; runts below MIN_WIDTH are discarded.
module sensor_pulse_capture #(
  parameter int TS_WIDTH   = 24,
  parameter int W_WIDTH    = 16,
  parameter int MIN_WIDTH  = 4,
  parameter int FILTER_LEN = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                envelope_in,
  input  logic [TS_WIDTH-1:0] timestamp,
  output logic                pulse_valid,
  input  logic                pulse_ready,
  output logic [TS_WIDTH-1:0] pulse_start,
  output logic [W_WIDTH-1:0]  pulse_width,
  output logic                overflow,
  input  logic                overflow_clear
);
  typedef enum logic {IDLE, HIGH} state_t;
  localparam logic [W_WIDTH-1:0] MIN_W = W_WIDTH'(MIN_WIDTH);
  logic                         r_s1, r_s2, r_s3, w_filt;
  state_t                       r_state, w_next;
  logic [TS_WIDTH-1:0]          r_start;
  logic [W_WIDTH-1:0]           r_width;
  logic [TS_WIDTH+W_WIDTH-1:0]  r_mem [4];
  logic [1:0]                   r_wp, r_rp;
  logic [2:0]                   r_cnt;
  logic                         r_ovf;
  logic                         w_rise, w_fall, w_rec, w_push, w_pop;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= envelope_in;
      r_s2 <= r_s1;
    end
  end
`ifdef SENSOR_PULSE_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic          r_flt;
  logic [CW-1:0] r_fcnt;
  // Level follows s2 only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flt  <= 1'b0;
      r_fcnt <= '0;
    end else if (r_s2 == r_flt) begin
      r_fcnt <= '0;
    end else if (r_fcnt == CW'(FILTER_LEN - 1)) begin
      r_flt  <= r_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + 1'b1;
    end
  end
  assign w_filt = r_flt;
`else
  assign w_filt = r_s2;
`endif
  assign w_rise = w_filt & ~r_s3;
  assign w_fall = ~w_filt & r_s3;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3    <= 1'b0;
      r_state <= IDLE;
    end else begin
      r_s3    <= w_filt;
      r_state <= w_next;
    end
  end
  always_comb begin
    w_next = r_state;
    w_rec  = 1'b0;
    if (r_state == IDLE && w_rise) w_next = HIGH;
    if (r_state == HIGH && w_fall) begin
      w_next = IDLE;
      w_rec  = r_width >= MIN_W;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start <= '0;
      r_width <= '0;
    end else if (r_state == IDLE && w_rise) begin
      r_start <= timestamp;
      r_width <= W_WIDTH'(1);
    end else if (r_state == HIGH && !w_fall && r_width != '1) begin
      r_width <= r_width + 1'b1;
    end
  end
  assign pulse_valid = r_cnt != 3'd0;
  assign w_pop       = pulse_valid & pulse_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign w_push      = w_rec & (r_cnt != 3'd4 | w_pop);
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {r_start, r_width};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + {1'b0, w_push};
      r_rp  <= r_rp + {1'b0, w_pop};
      r_cnt <= r_cnt + {2'b0, w_push} - {2'b0, w_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (reset) r_ovf <= 1'b0;
    else r_ovf <= (w_rec & ~w_push) ? 1'b1 : (overflow_clear ? 1'b0 : r_ovf);
  end
  assign overflow                   = r_ovf;
  assign {pulse_start, pulse_width} = pulse_valid ? r_mem[r_rp] : '0;
endmodule

// File: tb/tb_sensor_pulse_capture.sv
// tb_sensor_pulse_capture: directed and random pulse trains checked against a record-level reference model
module tb_sensor_pulse_capture;
  localparam int TSW  = 24;
  localparam int WW   = 4;
  localparam int MINW = 4;
  localparam int FL   = 3;
  localparam int MAXW = (1 << WW) - 1;
`ifdef SENSOR_PULSE_FILTER_EN
  localparam bit FILT = 1'b1;
  localparam int D    = FL;
`else
  localparam bit FILT = 1'b0;
  localparam int D    = 0;
`endif
  logic           clk = 1'b0, reset = 1'b1, envelope_in = 1'b0, pulse_ready = 1'b0, overflow_clear = 1'b0;
  logic [TSW-1:0] timestamp = '0;
  logic           pulse_valid, overflow;
  logic [TSW-1:0] pulse_start;
  logic [WW-1:0]  pulse_width;
  sensor_pulse_capture #(.TS_WIDTH(TSW), .W_WIDTH(WW), .MIN_WIDTH(MINW), .FILTER_LEN(FL)) dut (
    .clk(clk), .reset(reset), .envelope_in(envelope_in), .timestamp(timestamp),
    .pulse_valid(pulse_valid), .pulse_ready(pulse_ready), .pulse_start(pulse_start),
    .pulse_width(pulse_width), .overflow(overflow), .overflow_clear(overflow_clear)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0, n = 0;
  bit eh[$], fh[$];
  bit lev = 1'b0, m_ovf = 1'b0;
  logic [TSW-1:0] m_start = '0;
  int m_wid = 0;
  logic [TSW+WW-1:0] mq[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit at(input bit h[$], input int i);
    return (i < h.size()) ? h[i] : 1'b0;
  endfunction
  // Filtered level is the input delayed by sync (2 edges) and, with the filter, FL more;
  // records are whole high runs of that level, timed at the edge the run is first seen.
  task automatic model_step(input bit rst, input bit env, input logic [TSW-1:0] ts, input bit rdy, input bit oclr);
    bit pop, fa, fb, all_diff, drop;
    if (rst) begin
      eh.delete(); fh.delete(); mq.delete();
      lev = 1'b0; m_ovf = 1'b0; m_wid = 0; m_start = '0;
      return;
    end
    pop = rdy && mq.size() > 0;
    drop = 1'b0;
    eh.push_front(env);
    fh.push_front(FILT ? lev : env);
    all_diff = 1'b1;
    for (int i = 0; i < FL; i++) if (at(eh, i) == lev) all_diff = 1'b0;
    if (all_diff) lev = !lev;
    fa = at(fh, 2);
    fb = at(fh, 3);
    if (pop) void'(mq.pop_front());
    if (fa && !fb) begin
      m_start = ts;
      m_wid = 1;
    end else if (fa) m_wid = (m_wid < MAXW) ? m_wid + 1 : MAXW;
    if (!fa && fb && m_wid >= MINW) begin
      if (mq.size() < 4) mq.push_back({m_start, WW'(m_wid)});
      else drop = 1'b1;
    end
    m_ovf = drop ? 1'b1 : (oclr ? 1'b0 : m_ovf);
    while (eh.size() > 16) void'(eh.pop_back());
    while (fh.size() > 16) void'(fh.pop_back());
  endtask
  task automatic cycle(input bit env, input bit rdy, input bit oclr = 1'b0, input bit rst = 1'b0);
    logic [TSW+WW-1:0] h;
    @(negedge clk);
    h = (mq.size() > 0) ? mq[0] : '0;
    check("valid", pulse_valid, mq.size() > 0);
    check("start", pulse_start, h[TSW+WW-1:WW]);
    check("width", pulse_width, h[WW-1:0]);
    check("overflow", overflow, m_ovf);
    n++;
    timestamp = TSW'(n);
    envelope_in = env;
    pulse_ready = rdy;
    overflow_clear = oclr;
    reset = rst;
    model_step(rst, env, TSW'(n), rdy, oclr);
  endtask
  task automatic pulse(input int hi, input int lo, input bit rdy);
    repeat (hi) cycle(1'b1, rdy);
    repeat (lo) cycle(1'b0, rdy);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    model_step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    n = -1;
    repeat (5) cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b1, 1'b1);
    repeat (2 + D) cycle(1'b0, 1'b1);
    @(posedge clk); #1;
    check("basic_valid_early", pulse_valid, 1'b0);
    cycle(1'b0, 1'b1);
    @(posedge clk); #1;
    check("basic_valid", pulse_valid, 1'b1);
    check("basic_start", pulse_start, 7 + D);
    check("basic_width", pulse_width, 10);
    repeat (4) cycle(1'b0, 1'b1);
    pulse(3, 6, 1'b1);
    pulse(4, 8, 1'b1);
    pulse(2, 8, 1'b1);
    pulse(4, 2, 1'b1);
    pulse(4, 10, 1'b1);
    pulse(1, 1, 1'b1);
    pulse(5, 8, 1'b1);
    repeat (6) pulse(8, 4 + D, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    check("bp_overflow", overflow, 1'b1);
    check("bp_width", pulse_width, 8);
    repeat (12) cycle(1'b0, 1'b1);
    check("bp_drained", pulse_valid, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1);
    check("ovf_cleared", overflow, 1'b0);
    pulse(20, 8, 1'b1);
    repeat (5) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (6) cycle(1'b1, 1'b1);
    repeat (10) cycle(1'b0, 1'b1);
    repeat (300) begin
      int hi, lo;
      hi = $urandom_range(1, 24);
      lo = $urandom_range(1, 8);
      repeat (hi) cycle(1'b1, ($urandom % 4) != 0, ($urandom % 20) == 0, ($urandom % 400) == 0);
      repeat (lo) cycle(1'b0, ($urandom % 4) != 0, ($urandom % 20) == 0);
    end
    repeat (20) cycle(1'b0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
